// File: rtl/tc_to_sm_serial.sv
// Bit-serial two's-complement to sign-magnitude converter with valid/ready on both sides.
// Magnitude bits are processed LSB-first, one per clock, then held until the consumer takes them.
module tc_to_sm_serial #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] tc_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sm_out,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CONV = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state_r;
   logic [WIDTH-2:0] mag_r;
   logic             sign_r;
   logic             seen_one_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] sm_out_r;
   logic             ovf_r;
   logic             out_valid_r;
   logic             in_ready_r;

   logic             cur_bit_s;
   logic             out_bit_s;
   logic             seen_next_s;
   logic             last_s;
   logic             ovf_next_s;
   logic [WIDTH-2:0] mag_next_s;
   logic [WIDTH-1:0] sm_next_s;

   // Serial negation step: the converted bit enters at the top as the word shifts right.
   always_comb begin
      cur_bit_s   = mag_r[0];
      out_bit_s   = 1'b0;
      seen_next_s = seen_one_r | cur_bit_s;
      last_s      = (cnt_r == CNT_W'(WIDTH-2));
      mag_next_s  = mag_r >> 1;
      sm_next_s   = '0;
      if (sign_r) begin
         out_bit_s = cur_bit_s ^ seen_one_r;
      end else begin
         out_bit_s = cur_bit_s;
      end
      mag_next_s[WIDTH-2] = out_bit_s;
      // A negative word with no 1 in its magnitude is the most-negative value.
      ovf_next_s = sign_r & ~seen_next_s;
      if (ovf_next_s) begin
         sm_next_s = {WIDTH{1'b1}};
      end else begin
         sm_next_s = {sign_r, mag_next_s};
      end
   end

   // Control FSM, shift register and registered result/handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         mag_r       <= '0;
         sign_r      <= 1'b0;
         seen_one_r  <= 1'b0;
         cnt_r       <= '0;
         sm_out_r    <= '0;
         ovf_r       <= 1'b0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid && in_ready_r) begin
                  mag_r      <= tc_in[WIDTH-2:0];
                  sign_r     <= tc_in[WIDTH-1];
                  seen_one_r <= 1'b0;
                  cnt_r      <= '0;
                  in_ready_r <= 1'b0;
                  state_r    <= ST_CONV;
               end
            end
            ST_CONV: begin
               mag_r      <= mag_next_s;
               seen_one_r <= seen_next_s;
               if (last_s) begin
                  sm_out_r    <= sm_next_s;
                  ovf_r       <= ovf_next_s;
                  out_valid_r <= 1'b1;
                  state_r     <= ST_DONE;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            ST_DONE: begin
               // in_ready returns only after the result leaves, so no same-edge accept.
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign sm_out    = sm_out_r;
   assign ovf       = ovf_r;

endmodule

// File: tb/tb_tc_to_sm_serial.sv
// Directed testbench for tc_to_sm_serial at WIDTH=4 with hand-computed expectations.
module tb_tc_to_sm_serial;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] tc_in;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] sm_out;
   logic       ovf;

   int  vectors;
   int  miscompares;
   time accept_t;

   tc_to_sm_serial #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .tc_in     (tc_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sm_out    (sm_out),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Arithmetic reference, independent of the serial algorithm.
   function automatic logic [4:0] ref_sm(input logic [3:0] w);
      logic [3:0] neg;
      neg = 4'd0 - w;
      if (w == 4'b1000)  return {1'b1, 4'b1111};
      else if (w[3])     return {1'b0, 1'b1, neg[2:0]};
      else               return {1'b0, w};
   endfunction

   // Sends one word, waits for the result; consumes it at the next edge if out_ready is high.
   task automatic do_word(input logic [3:0] w, output logic [3:0] sm, output logic of,
                          output int lat);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      tc_in = w; in_valid = 1'b1;
      @(posedge clk); #1;
      accept_t = $time;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      if (!out_valid) lat = -1;
      sm = sm_out; of = ovf;
      if (out_ready) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; tc_in = 4'b0000; out_ready = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || sm_out !== 4'b0000 || ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL reset: got rdy=%b vld=%b sm=%b ovf=%b expected 1 0 0000 0",
                  in_ready, out_valid, sm_out, ovf);
      end
      @(posedge clk); #1; @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_positive();
      logic [3:0] sm; logic of; int lat;
      do_word(4'b0101, sm, of, lat);
      vectors++;
      if (sm !== 4'b0101 || of !== 1'b0) begin
         miscompares++;
         $display("FAIL pos5: got sm=%b ovf=%b expected 0101 0", sm, of);
      end
      vectors++;
      if (lat !== 3) begin
         miscompares++;
         $display("FAIL latency: got %0d edges expected 3", lat);
      end
   endtask

   task automatic test_negative();
      logic [3:0] vin [3];
      logic [3:0] vexp [3];
      logic [3:0] sm; logic of; int lat;
      vin[0] = 4'b1101; vexp[0] = 4'b1011;
      vin[1] = 4'b1111; vexp[1] = 4'b1001;
      vin[2] = 4'b1001; vexp[2] = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         do_word(vin[i], sm, of, lat);
         vectors++;
         if (sm !== vexp[i] || of !== 1'b0) begin
            miscompares++;
            $display("FAIL neg %b: got sm=%b ovf=%b expected %b 0", vin[i], sm, of, vexp[i]);
         end
      end
   endtask

   task automatic test_most_negative();
      logic [3:0] sm; logic of; int lat;
      do_word(4'b1000, sm, of, lat);
      vectors++;
      if (sm !== 4'b1111 || of !== 1'b1) begin
         miscompares++;
         $display("FAIL most_neg: got sm=%b ovf=%b expected 1111 1", sm, of);
      end
      do_word(4'b0000, sm, of, lat);
      vectors++;
      if (sm !== 4'b0000 || of !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_after_ovf: got sm=%b ovf=%b expected 0000 0", sm, of);
      end
   endtask

   task automatic test_sweep();
      logic [3:0] sm; logic of; int lat;
      logic [4:0] exp_v;
      time prev_t;
      prev_t = 0;
      for (int i = 0; i < 16; i++) begin
         do_word(4'(i), sm, of, lat);
         exp_v = ref_sm(4'(i));
         vectors++;
         if ({of, sm} !== exp_v) begin
            miscompares++;
            $display("FAIL sweep %0d: got ovf,sm=%b expected %b", i, {of, sm}, exp_v);
         end
         if (i > 0) begin
            vectors++;
            if (accept_t - prev_t != 50) begin
               miscompares++;
               $display("FAIL throughput %0d: got %0t between accepts expected 50", i,
                        accept_t - prev_t);
            end
         end
         prev_t = accept_t;
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] sm; logic of; int lat;
      int bad;
      out_ready = 1'b0;
      do_word(4'b1101, sm, of, lat);
      bad = 0;
      tc_in = 4'b0110; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || sm_out !== 4'b1011 || in_ready !== 1'b0 || ovf !== 1'b0)
            bad++;
      end
      in_valid = 1'b0;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL backpressure_hold: got %0d unstable cycles expected 0", bad);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL backpressure_release: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
      end
      do_word(4'b0010, sm, of, lat);
      vectors++;
      if (sm !== 4'b0010 || of !== 1'b0) begin
         miscompares++;
         $display("FAIL after_backpressure: got sm=%b ovf=%b expected 0010 0", sm, of);
      end
   endtask

   task automatic test_reset_mid_conv();
      logic [3:0] sm; logic of; int lat;
      int bad;
      tc_in = 4'b1110; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || sm_out !== 4'b0000 || ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_conv: got rdy=%b vld=%b sm=%b ovf=%b expected 1 0 0000 0",
                  in_ready, out_valid, sm_out, ovf);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL stale_result: got %0d cycles with out_valid expected 0", bad);
      end
      do_word(4'b0011, sm, of, lat);
      vectors++;
      if (sm !== 4'b0011 || of !== 1'b0 || lat !== 3) begin
         miscompares++;
         $display("FAIL post_reset: got sm=%b ovf=%b lat=%0d expected 0011 0 3", sm, of, lat);
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      accept_t = 0;
      test_reset();
      test_positive();
      test_negative();
      test_most_negative();
      test_sweep();
      test_backpressure();
      test_reset_mid_conv();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
